// File: rtl/reg_snap_pkg.sv
`default_nettype none
// ============================================================================
// reg_snap_pkg : shared state encoding and default sizes for reg_snapshot_server
// Rev 1.0
// ============================================================================
package reg_snap_pkg;

   localparam int C_DEF_DEPTH  = 32;
   localparam int C_DEF_ADDR_W = 9;
   localparam int C_DEF_DATA_W = 32;

   localparam logic [31:0] C_DEF_OOR_VALUE = 32'hDEADBEEF;

   typedef logic [1:0] state_t;

   localparam state_t ST_CLR   = 2'd0;
   localparam state_t ST_IDLE  = 2'd1;
   localparam state_t ST_ARMED = 2'd2;
   localparam state_t ST_COPY  = 2'd3;

endpackage : reg_snap_pkg
`default_nettype wire

// File: rtl/reg_snap_bank.sv
`default_nettype none
// ============================================================================
// reg_snap_bank : DEPTH x DATA_W register bank, one write port, one registered read port
// Rev 1.0
// ============================================================================
module reg_snap_bank #(
   parameter int DEPTH  = 32,
   parameter int DATA_W = 32
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     we_i,
   input  logic [$clog2(DEPTH)-1:0] waddr_i,
   input  logic [DATA_W-1:0]        wdata_i,
   input  logic [$clog2(DEPTH)-1:0] raddr_i,
   output logic [DATA_W-1:0]        rdata_o
);

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [DATA_W-1:0] rdata_q;

   // Contents are cleared by the owner's clear sequence, not by reset.
   always_ff @(posedge clk_i) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   // Read-first: a write on the same edge is not visible until the next read.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rdata_q <= '0;
      end else begin
         rdata_q <= mem_q[raddr_i];
      end
   end

   assign rdata_o = rdata_q;

endmodule : reg_snap_bank
`default_nettype wire

// File: rtl/reg_snapshot_server.sv
`default_nettype none
// ============================================================================
// reg_snapshot_server : double-buffered register file served to the display reader
// Rev 1.0 | optional macro REG_SNAP_CHANGED_EN adds the register_changed output
// ============================================================================
module reg_snapshot_server
   import reg_snap_pkg::*;
#(
   parameter int                DEPTH     = C_DEF_DEPTH,
   parameter int                ADDR_W    = C_DEF_ADDR_W,
   parameter int                DATA_W    = C_DEF_DATA_W,
   parameter logic [DATA_W-1:0] OOR_VALUE = DATA_W'(C_DEF_OOR_VALUE)
) (
   input  logic                     CLOCK_50,
   input  logic                     reset,
   input  logic                     wr_en,
   input  logic [$clog2(DEPTH)-1:0] wr_addr,
   input  logic [DATA_W-1:0]        wr_data,
   input  logic                     snap_req,
   input  logic [ADDR_W-1:0]        addr,
   input  logic                     finished_register,
   output logic [DATA_W-1:0]        register_value,
`ifdef REG_SNAP_CHANGED_EN
   output logic                     register_changed,
`endif
   output logic                     snap_busy,
   output logic [15:0]              snap_count
);

   localparam int              IW        = $clog2(DEPTH);
   localparam logic [IW-1:0]   LAST_IDX  = IW'(DEPTH - 1);
   localparam logic [ADDR_W:0] DEPTH_EXT = (ADDR_W + 1)'(DEPTH);

   state_t            state_q, state_d;
   logic [IW-1:0]     idx_q, idx_d;
   logic              pending_q, pending_d;
   logic              fin_q, busy_q;
   logic [15:0]       count_q;
   logic              fwd_v_q, view_q, oor_q;
   logic [DATA_W-1:0] fwd_data_q, hold_q;

   logic              fe, in_clr, in_copy, collide, addr_oor;
   logic              sh_we, dp_we;
   logic [IW-1:0]     sh_waddr, sh_raddr, dp_raddr, addr_idx;
   logic [DATA_W-1:0] sh_wdata, sh_rdata, dp_wdata, dp_rdata, copy_src, copy_data;

   assign fe       = finished_register & ~fin_q;
   assign in_clr   = (state_q == ST_CLR);
   assign in_copy  = (state_q == ST_COPY);
   assign addr_idx = addr[IW-1:0];
   assign addr_oor = ({1'b0, addr} >= DEPTH_EXT);

   always_comb begin
      state_d   = state_q;
      idx_d     = '0;
      pending_d = pending_q;
      case (state_q)
         ST_CLR: begin
            if (idx_q == LAST_IDX) state_d = ST_IDLE;
            else                   idx_d   = idx_q + 1'b1;
         end
         ST_IDLE: begin
            if (snap_req) state_d = ST_ARMED;
         end
         ST_ARMED: begin
            if (fe) begin
               state_d   = ST_COPY;
               pending_d = 1'b0;
            end
         end
         default: begin
            if (snap_req) pending_d = 1'b1;
            if (idx_q == LAST_IDX) begin
               state_d   = (pending_q | snap_req) ? ST_ARMED : ST_IDLE;
               pending_d = 1'b0;
            end else begin
               idx_d = idx_q + 1'b1;
            end
         end
      endcase
   end

   // Shadow is pre-read at the next copy index; a write to that index on the
   // same edge is missed by the read-first bank, so it is caught by fwd_*.
   assign sh_we     = in_clr | wr_en;
   assign sh_waddr  = in_clr ? idx_q : wr_addr;
   assign sh_wdata  = in_clr ? '0 : wr_data;
   assign sh_raddr  = idx_d;
   assign copy_src  = fwd_v_q ? fwd_data_q : sh_rdata;
   assign collide   = wr_en & (wr_addr == idx_q);
   assign copy_data = collide ? wr_data : copy_src;

   assign dp_we     = in_clr | in_copy;
   assign dp_wdata  = in_copy ? copy_data : '0;
   assign dp_raddr  = in_copy ? idx_q : addr_idx;

   reg_snap_bank #(.DEPTH(DEPTH), .DATA_W(DATA_W)) u_shadow (
      .clk_i   (CLOCK_50),
      .rst_i   (reset),
      .we_i    (sh_we),
      .waddr_i (sh_waddr),
      .wdata_i (sh_wdata),
      .raddr_i (sh_raddr),
      .rdata_o (sh_rdata)
   );

   reg_snap_bank #(.DEPTH(DEPTH), .DATA_W(DATA_W)) u_display (
      .clk_i   (CLOCK_50),
      .rst_i   (reset),
      .we_i    (dp_we),
      .waddr_i (idx_q),
      .wdata_i (dp_wdata),
      .raddr_i (dp_raddr),
      .rdata_o (dp_rdata)
   );

   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         state_q    <= ST_CLR;
         idx_q      <= '0;
         pending_q  <= 1'b0;
         fin_q      <= 1'b0;
         busy_q     <= 1'b0;
         count_q    <= '0;
         fwd_v_q    <= 1'b0;
         fwd_data_q <= '0;
         view_q     <= 1'b0;
         oor_q      <= 1'b0;
         hold_q     <= '0;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         pending_q  <= pending_d;
         fin_q      <= finished_register;
         busy_q     <= (state_q != ST_IDLE);
         if (in_copy && (idx_q == LAST_IDX)) count_q <= count_q + 16'd1;
         fwd_v_q    <= sh_we & (sh_waddr == sh_raddr);
         fwd_data_q <= sh_wdata;
         // While copying the display read port belongs to the copy engine.
         view_q     <= ~in_copy;
         if (!in_copy) oor_q <= addr_oor;
         hold_q     <= register_value;
      end
   end

   assign register_value = view_q ? (oor_q ? OOR_VALUE : dp_rdata) : hold_q;
   assign snap_busy      = busy_q;
   assign snap_count     = count_q;

`ifdef REG_SNAP_CHANGED_EN
   logic [DEPTH-1:0]  dirty_q;
   logic              cmp_v_q, changed_q, cmp_hit;
   logic [IW-1:0]     cmp_idx_q;
   logic [DATA_W-1:0] cmp_data_q;

   // dp_rdata carries the pre-copy word of the index written one cycle earlier.
   assign cmp_hit = cmp_v_q & (cmp_data_q != dp_rdata);

   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         dirty_q    <= '0;
         cmp_v_q    <= 1'b0;
         cmp_idx_q  <= '0;
         cmp_data_q <= '0;
         changed_q  <= 1'b0;
      end else begin
         cmp_v_q    <= in_copy;
         cmp_idx_q  <= idx_q;
         cmp_data_q <= copy_data;
         if (cmp_hit) dirty_q[cmp_idx_q] <= 1'b1;
         if ((state_q == ST_ARMED) && fe) dirty_q <= '0;
         if (!in_copy) begin
            changed_q <= ~addr_oor &
                         (dirty_q[addr_idx] | (cmp_hit & (cmp_idx_q == addr_idx)));
         end
      end
   end

   assign register_changed = changed_q;
`endif

endmodule : reg_snapshot_server
`default_nettype wire

// File: tb/tb_reg_snapshot_server.sv
`default_nettype none
// ============================================================================
// tb_reg_snapshot_server : directed bench with a spec-level model of reg_snapshot_server
// Rev 1.0
// ============================================================================
module tb_reg_snapshot_server;

   localparam int          DEPTH = 32;
   localparam logic [31:0] OOR   = 32'hDEADBEEF;
   localparam int M_CLR = 0, M_IDLE = 1, M_ARMED = 2, M_COPY = 3;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        wr_en = 1'b0;
   logic [4:0]  wr_addr = '0;
   logic [31:0] wr_data = '0;
   logic        snap_req = 1'b0;
   logic [8:0]  addr = '0;
   logic        finished_register = 1'b0;
   logic [31:0] register_value;
   logic        snap_busy;
   logic [15:0] snap_count;
`ifdef REG_SNAP_CHANGED_EN
   logic        register_changed;
`endif

   reg_snapshot_server dut (
      .CLOCK_50          (clk),
      .reset             (reset),
      .wr_en             (wr_en),
      .wr_addr           (wr_addr),
      .wr_data           (wr_data),
      .snap_req          (snap_req),
      .addr              (addr),
      .finished_register (finished_register),
      .register_value    (register_value),
`ifdef REG_SNAP_CHANGED_EN
      .register_changed  (register_changed),
`endif
      .snap_busy         (snap_busy),
      .snap_count        (snap_count)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: what the reader must observe, from the register-file rules.
   logic [31:0] m_shadow [DEPTH];
   logic [31:0] m_disp   [DEPTH];
   bit          m_known  [DEPTH];
   int          m_mode = M_CLR;
   int          m_i = 0;
   bit          m_pend = 0, m_fin = 0, m_busy = 0, m_valid = 0, m_rv_known = 0;
   logic [31:0] m_rv = '0;
   logic [15:0] m_cnt = '0;

   task automatic model_step();
      bit fe;
      if (reset) begin
         m_mode = M_CLR; m_i = 0; m_pend = 0; m_fin = 0; m_busy = 0;
         m_cnt = '0; m_rv = '0; m_rv_known = 1; m_valid = 1;
         return;
      end
      fe    = finished_register && !m_fin;
      m_fin = finished_register;
      if (m_mode != M_COPY) begin
         if (addr >= 9'(DEPTH)) begin
            m_rv = OOR; m_rv_known = 1;
         end else begin
            m_rv = m_disp[addr[4:0]]; m_rv_known = m_known[addr[4:0]];
         end
      end
      m_busy = (m_mode != M_IDLE);
      case (m_mode)
         M_CLR: begin
            m_shadow[m_i] = '0; m_disp[m_i] = '0; m_known[m_i] = 1;
            if (m_i == DEPTH - 1) begin m_mode = M_IDLE; m_i = 0; end
            else m_i++;
         end
         M_IDLE: begin
            if (wr_en) m_shadow[wr_addr] = wr_data;
            if (snap_req) m_mode = M_ARMED;
         end
         M_ARMED: begin
            if (wr_en) m_shadow[wr_addr] = wr_data;
            if (fe) begin m_mode = M_COPY; m_i = 0; end
         end
         default: begin
            m_disp[m_i] = (wr_en && (int'(wr_addr) == m_i)) ? wr_data : m_shadow[m_i];
            if (wr_en) m_shadow[wr_addr] = wr_data;
            if (snap_req) m_pend = 1;
            if (m_i == DEPTH - 1) begin
               m_cnt++; m_mode = m_pend ? M_ARMED : M_IDLE; m_pend = 0; m_i = 0;
            end else begin
               m_i++;
            end
         end
      endcase
   endtask

   initial forever begin
      @(posedge clk);
      model_step();
   end

   initial forever begin
      @(negedge clk);
      if (m_valid) begin
         if (m_rv_known) chk("register_value", register_value, m_rv);
         chk("snap_busy", {31'b0, snap_busy}, {31'b0, m_busy});
         chk("snap_count", {16'b0, snap_count}, {16'b0, m_cnt});
      end
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic read_lit(input logic [8:0] a, input logic [31:0] exp);
      addr = a;
      tick();
      chk($sformatf("read addr %0d", a), register_value, exp);
   endtask

   task automatic write_shadow(input logic [4:0] a, input logic [31:0] d);
      wr_en = 1'b1; wr_addr = a; wr_data = d;
      tick();
      wr_en = 1'b0;
   endtask

   int busy_cycles;

   initial begin
      // Reset and clear sequence
      repeat (2) tick();
      reset = 1'b0;
      chk("reset register_value", register_value, 32'h0);
      chk("reset snap_busy", {31'b0, snap_busy}, 32'h0);
      chk("reset snap_count", {16'b0, snap_count}, 32'h0);
      repeat (33) tick();
      for (int a = 0; a < DEPTH; a++) read_lit(9'(a), 32'h0);
      read_lit(9'd40, 32'hDEADBEEF);

      // Shadow write is invisible until a snapshot
      write_shadow(5'd5, 32'hFEEDF00D);
      read_lit(9'd5, 32'h0);
      snap_req = 1'b1; tick(); snap_req = 1'b0;
      tick();
      snap_req = 1'b1; tick(); snap_req = 1'b0;
      finished_register = 1'b1; tick(); finished_register = 1'b0;
      repeat (34) tick();
      read_lit(9'd5, 32'hFEEDF00D);
      chk("count after first copy", {16'b0, snap_count}, 32'd1);
      chk("idle after absorbed req", {31'b0, snap_busy}, 32'h0);

      // snap_req and fe together in IDLE only arm
      snap_req = 1'b1; finished_register = 1'b1; tick();
      snap_req = 1'b0;
      tick();
      write_shadow(5'd9, 32'hAAAA5555);
      read_lit(9'd9, 32'h0);
      chk("armed busy", {31'b0, snap_busy}, 32'd1);
      chk("no copy on joint edge", {16'b0, snap_count}, 32'd1);
      finished_register = 1'b0; tick();
      finished_register = 1'b1; tick();
      finished_register = 1'b0;
      // Now in copy index 0; collide at index 7, request at index 10
      repeat (7) tick();
      write_shadow(5'd7, 32'h12345678);
      repeat (2) tick();
      snap_req = 1'b1; tick(); snap_req = 1'b0;
      repeat (23) tick();
      chk("re-armed after copy", {31'b0, snap_busy}, 32'd1);
      chk("count after second copy", {16'b0, snap_count}, 32'd2);
      read_lit(9'd7, 32'h12345678);
      read_lit(9'd9, 32'hAAAA5555);
      read_lit(9'd5, 32'hFEEDF00D);
      read_lit(9'd300, 32'hDEADBEEF);

      // Reset in the middle of the pending copy
      write_shadow(5'd3, 32'h33333333);
      finished_register = 1'b1; tick(); finished_register = 1'b0;
      repeat (10) tick();
      reset = 1'b1; tick(); reset = 1'b0;
      chk("mid-copy reset register_value", register_value, 32'h0);
      chk("mid-copy reset snap_count", {16'b0, snap_count}, 32'h0);
      busy_cycles = 0;
      for (int c = 0; c < 40; c++) begin
         if (snap_busy) busy_cycles++;
         tick();
      end
      chk("busy cycles during clear", busy_cycles, 32'd32);
      read_lit(9'd3, 32'h0);
      read_lit(9'd5, 32'h0);
      read_lit(9'd7, 32'h0);
      read_lit(9'd9, 32'h0);
      chk("count after clear", {16'b0, snap_count}, 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete, failures so far %0d", n_fail);
      $fatal(1);
   end

endmodule : tb_reg_snapshot_server
`default_nettype wire
